// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, field positions, encodings and store-lane helpers for
// the b-risc MEM/WB stage.
//   WORD_W / ADDR_W / REG_IDX_W / DEST_SRC_W / MEM_OP_W : datapath widths
//   mem_op layout : {store, unsigned, size[1:0]}, size 0=B 1=H 2=W 3=illegal
//   dest_src_e    : write-back source selector shared with the ID stage
//   state_e       : MEM/WB control states
package mem_wb_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned DEST_SRC_W = 2;
    localparam int unsigned MEM_OP_W   = 4;

    localparam int unsigned MEM_OP_STORE    = 3;
    localparam int unsigned MEM_OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } mem_size_e;

    typedef enum logic [DEST_SRC_W-1:0] {
        DEST_SRC_ALU  = 2'd0,
        DEST_SRC_MEM  = 2'd1,
        DEST_SRC_NONE = 2'd2
    } dest_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Natural alignment; size 3 is never a legal access.
    function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~off[0];
            SIZE_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SIZE_B:  strb = 4'b0001 << off;
            SIZE_H:  strb = off[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data is replicated across every lane so the strobe alone selects the target bytes.
    function automatic logic [WORD_W-1:0] store_wdata(input logic [1:0] size, input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] w;
        case (size)
            SIZE_B:  w = {4{d[7:0]}};
            SIZE_H:  w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// mem_wb_load_align: combinational load lane select and sign/zero extension.
//   byte_off_i : low address bits of the load
//   size_i     : access size (B/H/W)
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   rdata_i    : full word returned by memory
//   word_o     : register-file ready value
module mem_wb_load_align
    import mem_wb_pkg::*;
(
    input  logic [1:0]        byte_off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [WORD_W-1:0] word_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[8*byte_off_i +: 8];
        half_lane = rdata_i[16*byte_off_i[1] +: 16];
        case (size_i)
            SIZE_B:  word_o = unsigned_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SIZE_H:  word_o = unsigned_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: word_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// mem_wb: memory-access + write-back stage of the b-risc pipeline.
//   clk, clr                : clock, synchronous active-high reset
//   ex_*                    : instruction presented by EX (held by upstream while stall=1)
//   stall                   : stage busy with a memory transaction
//   mem_req_* / mem_rsp_*   : valid/ready data-memory port, word-aligned addresses
//   wb_dest_en/reg/data     : register-file write port (single-cycle pulse)
//   exc_misalign            : one-cycle pulse when a misaligned/illegal access is dropped
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ex_valid,
    input  logic [WORD_W-1:0]     ex_alu_result,
    input  logic [WORD_W-1:0]     ex_store_data,
    input  logic                  ex_mem_en,
    input  logic [MEM_OP_W-1:0]   ex_mem_op,
    input  logic [DEST_SRC_W-1:0] ex_dest_src,
    input  logic [REG_IDX_W-1:0]  ex_dest_reg,
    output logic                  stall,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_we,
    output logic [3:0]            mem_req_wstrb,
    output logic [WORD_W-1:0]     mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [WORD_W-1:0]     mem_rsp_rdata,
    output logic                  wb_dest_en,
    output logic [REG_IDX_W-1:0]  wb_dest_reg,
    output logic [WORD_W-1:0]     wb_dest_data,
    output logic                  exc_misalign
);

    state_e                 state_q, state_d;
    logic [MEM_OP_W-1:0]    op_q, op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_W-1:0]      sdata_q, sdata_d;
    logic [REG_IDX_W-1:0]   rd_q, rd_d;
    logic                   wb_en_q, wb_en_d;
    logic [REG_IDX_W-1:0]   wb_reg_q, wb_reg_d;
    logic [WORD_W-1:0]      wb_data_q, wb_data_d;
    logic                   exc_q, exc_d;
    logic [WORD_W-1:0]      load_word;
    logic                   req_active;

    mem_wb_load_align u_load_align (
        .byte_off_i (addr_q[1:0]),
        .size_i     (op_q[1:0]),
        .unsigned_i (op_q[MEM_OP_UNSIGNED]),
        .rdata_i    (mem_rsp_rdata),
        .word_o     (load_word)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            exc_q     <= exc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        rd_d      = rd_q;
        wb_en_d   = 1'b0;
        wb_reg_d  = '0;
        wb_data_d = '0;
        exc_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_en) begin
                        if (access_aligned(ex_mem_op[1:0], ex_alu_result[1:0])) begin
                            op_d    = ex_mem_op;
                            addr_d  = ex_alu_result;
                            sdata_d = ex_store_data;
                            rd_d    = ex_dest_reg;
                            state_d = ST_REQ;
                        end else begin
                            exc_d = 1'b1;
                        end
                    end else if (ex_dest_src == DEST_SRC_ALU && ex_dest_reg != '0) begin
                        wb_en_d   = 1'b1;
                        wb_reg_d  = ex_dest_reg;
                        wb_data_d = ex_alu_result;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = op_q[MEM_OP_STORE] ? ST_IDLE : ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    state_d = ST_IDLE;
                    if (rd_q != '0) begin
                        wb_en_d   = 1'b1;
                        wb_reg_d  = rd_q;
                        wb_data_d = load_word;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are derived from latched state only, so they cannot move while REQ waits.
    always_comb begin
        req_active    = (state_q == ST_REQ);
        stall         = (state_q != ST_IDLE);
        mem_req_valid = req_active;
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        mem_req_wstrb = '0;
        mem_req_wdata = '0;
        if (req_active) begin
            mem_req_addr = {addr_q[ADDR_W-1:2], 2'b00};
            mem_req_we   = op_q[MEM_OP_STORE];
            if (op_q[MEM_OP_STORE]) begin
                mem_req_wstrb = store_wstrb(op_q[1:0], addr_q[1:0]);
                mem_req_wdata = store_wdata(op_q[1:0], sdata_q);
            end
        end
    end

    assign wb_dest_en   = wb_en_q;
    assign wb_dest_reg  = wb_reg_q;
    assign wb_dest_data = wb_data_q;
    assign exc_misalign = exc_q;

endmodule
